// File: rtl/dm11a88_scan.sv
// +----------------------------------------------------------------------------+
// | dm11a88_scan: row-scanning driver for CHAIN cascaded DM11A88 8x8 matrices   |
// | Optional double-buffered frame store under `define FRAME_SWAP_EN            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module dm11a88_scan #(
  parameter int CHAIN      = 1,
  parameter int CLK_DIV    = 2,
  parameter int LAT_CYCLES = 2,
  parameter int ROW_HOLD   = 10000
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 wr_en,
  input  logic [2:0]           wr_row,
  input  logic [8*CHAIN-1:0]   wr_data,
`ifdef FRAME_SWAP_EN
  input  logic                 swap,
  output logic                 swap_pending,
`endif
  output logic                 vcc,
  output logic                 gnd,
  output logic                 di,
  output logic                 clk,
  output logic                 lat,
  output logic [2:0]           row_idx,
  output logic                 frame_start
);

  localparam int c_cols    = 8 * CHAIN;
  localparam int c_nbits   = 16 * CHAIN;
  localparam int c_ph_w    = $clog2(2 * CLK_DIV);
  localparam int c_bit_w   = $clog2(c_nbits);
  localparam int c_cnt_max = (LAT_CYCLES > ROW_HOLD) ? LAT_CYCLES : ROW_HOLD;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_ph_w-1:0]  c_ph_last   = c_ph_w'(2 * CLK_DIV - 1);
  localparam logic [c_ph_w-1:0]  c_ph_high   = c_ph_w'(CLK_DIV);
  localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(c_nbits - 1);
  localparam logic [c_cnt_w-1:0] c_lat_last  = c_cnt_w'(LAT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(ROW_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_nbits-1:0]   r_sh;
  logic [c_ph_w-1:0]    r_ph;
  logic [c_bit_w-1:0]   r_bit;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_row;

  logic [c_cols-1:0]    w_pix;
  logic [c_nbits-1:0]   w_word;
  logic [7:0]           w_rowsel;
  logic                 w_bit_done;
  logic                 w_last_bit;
  logic                 w_lat_done;
  logic                 w_hold_done;
  logic                 w_row_end;

  assign w_bit_done  = (r_ph == c_ph_last);
  assign w_last_bit  = (r_bit == c_bit_last);
  assign w_lat_done  = (r_cnt == c_lat_last);
  assign w_hold_done = (r_cnt == c_hold_last);
  assign w_row_end   = (r_state == S_HOLD) && w_hold_done;

  // Frame store; the scan side reads it combinationally so LOAD sees pre-write contents.
`ifdef FRAME_SWAP_EN
  logic [c_cols-1:0] r_fb [2][8];
  logic              r_front;
  logic              r_pend;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++) begin
          r_fb[b][i] <= '0;
        end
      end
      r_front <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      if (wr_en) begin
        r_fb[~r_front][wr_row] <= wr_data;
      end
      if (w_row_end && (r_row == 3'd7) && r_pend) begin
        r_front <= ~r_front;
        r_pend  <= 1'b0;
      end else if (swap) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign w_pix        = r_fb[r_front][r_row];
  assign swap_pending = r_pend;
`else
  logic [c_cols-1:0] r_fb [8];

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_fb[i] <= '0;
      end
    end else if (wr_en) begin
      r_fb[wr_row] <= wr_data;
    end
  end

  assign w_pix = r_fb[r_row];
`endif

  // Module CHAIN-1 occupies the low word so it leaves the LSB-first shifter first.
  assign w_rowsel = ~(8'd1 << r_row);

  generate
    for (genvar m = 0; m < CHAIN; m++) begin : g_word
      assign w_word[16*(CHAIN-1-m) +: 16] = {~w_pix[8*m +: 8], w_rowsel};
    end
  endgenerate

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (en) w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (w_bit_done && w_last_bit) w_next = S_LATCH;
      S_LATCH: if (w_lat_done) w_next = S_HOLD;
      S_HOLD:  if (w_hold_done) w_next = en ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_sh  <= '0;
      r_ph  <= '0;
      r_bit <= '0;
      r_cnt <= '0;
      r_row <= 3'd0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_sh  <= w_word;
          r_ph  <= '0;
          r_bit <= '0;
        end
        S_SHIFT: begin
          if (w_bit_done) begin
            r_ph <= '0;
            if (w_last_bit) begin
              r_cnt <= '0;
            end else begin
              r_bit <= r_bit + 1'b1;
              r_sh  <= r_sh >> 1;
            end
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        S_LATCH: begin
          r_cnt <= w_lat_done ? '0 : r_cnt + 1'b1;
        end
        S_HOLD: begin
          if (w_hold_done) begin
            r_row <= r_row + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign vcc         = 1'b1;
  assign gnd         = 1'b0;
  assign di          = (r_state == S_SHIFT) && r_sh[0];
  assign clk         = (r_state == S_SHIFT) && (r_ph >= c_ph_high);
  assign lat         = (r_state == S_LATCH);
  assign row_idx     = r_row;
  assign frame_start = (r_state == S_LOAD) && (r_row == 3'd0);

endmodule

`default_nettype wire

// File: doc/dm11a88_scan.md
Name: dm11a88_scan

Overview:
- Parametrised successor to the single-module DM11A88 driver.
- Refreshes a chain of CHAIN cascaded 8x8 DM11A88 LED matrix modules, one row at a time, through the serial di/clk/lat shift interface.
- Holds an internal frame buffer that a host writes one row at a time. Performs continuous row scanning with a programmable serial clock rate, latch width and row dwell time.
- Sits between the pixel-generating logic and the board pins.

Parameters:
CHAIN, 1, number of cascaded 8x8 modules; total columns COLS = 8*CHAIN
CLK_DIV, 2, clk_50m cycles per serial-clock half period (>=1)
LAT_CYCLES, 2, clk_50m cycles lat is held high per row (>=1)
ROW_HOLD, 10000, clk_50m cycles of dwell after latch before the next row (>=1)

Ports:
clk_50m  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
en  input  1  scan enable; sampled only in IDLE and at row boundaries
wr_en  input  1  frame-buffer row write strobe
wr_row  input  3  row address, 0..7
wr_data  input  COLS  pixel bits for that row; bit c = column c, 1 = LED on
vcc  output  1  constant 1 (module supply)
gnd  output  1  constant 0 (module ground)
di  output  1  serial data
clk  output  1  serial shift clock
lat  output  1  storage-register latch
row_idx  output  3  row currently displayed
frame_start  output  1  one-cycle pulse when row 0 shifting begins

Behaviour:
- Reset values (rst=1 on a clock edge): di=0, clk=0, lat=0, row_idx=0, frame_start=0, FSM=IDLE, frame buffer cleared to all 0 (all LEDs off). Reset mid-shift aborts immediately; no partial latch is issued.
- Per-module 16-bit word:
  - bits[7:0] = row select, active-low one-hot: bit r = 0 only for the row being scanned.
  - bits[15:8] = column drive, active-low: bit 8+k = ~pixel[row][8*m+k] for module m.
- Shift order:
  - Module CHAIN-1 is shifted first and module 0 last.
  - Within each word, LSB first.
  - Total NBITS = 16*CHAIN bits per row.
- FSM states:
  - IDLE: outputs at reset values. If en=1, go to LOAD.
  - LOAD (1 cycle): capture the row word for row_idx from the frame buffer into the shift register. Reset the bit counter. Pulse frame_start if row_idx==0. Go to SHIFT.
  - SHIFT: each bit takes 2*CLK_DIV cycles.
    - First half: clk=0, with di driven with the bit on the first cycle.
    - Second half: clk=1.
    - After the second half of bit NBITS-1, clk returns to 0 and the FSM goes to LATCH.
    - di is stable for the whole clk-high half and the preceding low half.
  - LATCH: lat=1 for exactly LAT_CYCLES cycles, clk=0, then go to HOLD.
  - HOLD: lat=0 for ROW_HOLD cycles. Then row_idx wraps (7 -> 0) or increments, and the FSM goes to LOAD if en=1, else IDLE.
- en deasserted during SHIFT/LATCH/HOLD: the current row completes; the stop is taken at the end of HOLD.
- Frame-buffer writes:
  - wr_en=1 stores wr_data to row wr_row on that edge, in any state.
  - A write to the row being shifted does not disturb it, because the word was captured at LOAD. The new data appears on that row's next scan.
- A write and LOAD of the same row in the same cycle: LOAD captures the OLD contents.
- Counters are sized ceil(log2()) of their terminal count. No counter wraps except row_idx.
- Row period = 1 + NBITS*2*CLK_DIV + LAT_CYCLES + ROW_HOLD cycles.

Optional Feature:
- Macro FRAME_SWAP_EN.
- When defined:
  - Two frame buffers are present, plus extra ports: swap input (1 bit) and swap_pending output (1 bit).
  - wr_en writes the back buffer; scanning reads the front buffer.
  - A swap pulse sets swap_pending. The exchange happens at the end of HOLD of row 7, which clears swap_pending, so a frame is never torn.
  - Swap asserted while already pending has no further effect.
  - Reset clears both buffers and swap_pending.
- When undefined: a single buffer; writes are visible on the next LOAD of that row; no swap ports.

Test Plan:
1. CHAIN=1, CLK_DIV=2, LAT_CYCLES=2, ROW_HOLD=100; all pixels 0; en=1 -> row 0 shifts 16 bits, 64 cycles, di sequence 0,1,1,1,1,1,1,1 then eight 1s. lat high for exactly 2 cycles. Next LOAD occurs 167 cycles after the first LOAD.
2. Write row 3 = 8'hA5, scan to row 3 -> column bits shifted = ~A5 LSB first: 0,1,0,1,1,0,1,0. row_idx=3 during shift.
3. CHAIN=2; write row 0 = 16'h00FF -> the first 16 bits shifted (module 1) carry columns 0xFF (no LEDs on). The second 16 bits (module 0) carry columns 0x00 (all on). 32 clk rising edges precede lat.
4. Assert rst at bit 5 of SHIFT -> next cycle di=0, clk=0, lat=0, row_idx=0, FSM IDLE. No lat pulse occurs.
5. Deassert en during SHIFT of row 2 -> row 2 completes its latch and hold. row_idx becomes 3. FSM enters IDLE with no further clk edges.
6. FRAME_SWAP_EN: write back buffer, pulse swap at row 4 -> swap_pending=1 until the end of row 7 hold. Row 0 of the next frame shows the new data. frame_start pulses once.
